hybrid_cache: RTL and testbench

//  Shared L1 between the CPU and a single-port word memory: write-back, write-allocate

---
 rtl/hybrid_cache.sv | 267 ++++++++++++++++++++++++++
 tb/tb_hybrid_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_cache.sv
// Shared L1 for one CPU: write-back/write-allocate dcache plus read-only icache,
// served one request at a time by a single controller that owns the word-memory port.

module hybrid_cache_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign ready   = (count != CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end
endmodule

module hybrid_cache #(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int WORDLENBITS = 2,
  parameter int LINEBITS    = 3,
  parameter int WORDBITS    = 2,
  parameter int QDEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDRBITS-1:0]    dcache_rdaddr,
  input  logic                   dcache_rdreq,
  output logic [DATABITS-1:0]    dcache_out,
  output logic                   dcache_out_valid,
  output logic                   dcache_rd_ready,
  input  logic [ADDRBITS-1:0]    dcache_wraddr,
  input  logic                   dcache_wrreq,
  input  logic [DATABITS-1:0]    dcache_in,
  input  logic [WORDLENBITS-1:0] dcache_in_wordlen,
  output logic                   dcache_wr_ready,
  input  logic [ADDRBITS-1:0]    icache_rdaddr,
  input  logic                   icache_rdreq,
  output logic [DATABITS-1:0]    icache_out,
  output logic                   icache_out_valid,
  output logic                   icache_rd_ready,
  output logic [ADDRBITS-1:0]    mem_addr,
  output logic [DATABITS-1:0]    mem_in,
  input  logic [DATABITS-1:0]    mem_out,
  input  logic                   mem_out_valid,
  output logic                   mem_wrreq,
  output logic                   mem_rdreq
);
  localparam int LINES   = 1 << LINEBITS;
  localparam int WORDS   = 1 << WORDBITS;
  localparam int IDX_LSB = 2 + WORDBITS;
  localparam int TAG_LSB = IDX_LSB + LINEBITS;
  localparam int TAGW    = ADDRBITS - TAG_LSB;
  localparam int WFW     = ADDRBITS + DATABITS + WORDLENBITS;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_WB = 3'd2, S_FILL = 3'd3, S_HIT_DONE = 3'd4;
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_IF = 2'd2;

  logic [WFW-1:0]         wf_dout;
  logic [ADDRBITS-1:0]    wf_addr, rf_dout, if_dout;
  logic [DATABITS-1:0]    wf_data;
  logic [WORDLENBITS-1:0] wf_len;
  logic                   wf_empty, rf_empty, if_empty;
  logic                   pop_wr, pop_rd, pop_if;

  logic [2:0]             state;
  logic [1:0]             op;
  logic [ADDRBITS-1:0]    req_addr;
  logic [DATABITS-1:0]    req_data;
  logic [WORDLENBITS-1:0] req_len;
  logic [WORDBITS-1:0]    cnt;
  logic                   waiting;

  logic [LINES-1:0]       d_valid, d_dirty, i_valid;
  logic [TAGW-1:0]        d_tag [LINES];
  logic [TAGW-1:0]        i_tag [LINES];
  logic [DATABITS-1:0]    d_data [LINES][WORDS];
  logic [DATABITS-1:0]    i_data [LINES][WORDS];

  logic [LINEBITS-1:0]    idx;
  logic [WORDBITS-1:0]    off;
  logic [TAGW-1:0]        tag;
  logic                   d_tag_eq, hit, need_wb, fill_beat, last_word;

  hybrid_cache_fifo #(.W(WFW), .DEPTH(QDEPTH)) u_wr_fifo (
    .clk, .reset_n, .push(dcache_wrreq), .pop(pop_wr),
    .din({dcache_wraddr, dcache_in, dcache_in_wordlen}), .dout(wf_dout),
    .empty(wf_empty), .ready(dcache_wr_ready)
  );
  hybrid_cache_fifo #(.W(ADDRBITS), .DEPTH(QDEPTH)) u_rd_fifo (
    .clk, .reset_n, .push(dcache_rdreq), .pop(pop_rd), .din(dcache_rdaddr),
    .dout(rf_dout), .empty(rf_empty), .ready(dcache_rd_ready)
  );
  hybrid_cache_fifo #(.W(ADDRBITS), .DEPTH(QDEPTH)) u_if_fifo (
    .clk, .reset_n, .push(icache_rdreq), .pop(pop_if), .din(icache_rdaddr),
    .dout(if_dout), .empty(if_empty), .ready(icache_rd_ready)
  );

  assign {wf_addr, wf_data, wf_len} = wf_dout;

  // Fixed priority: stores, then data reads, then fetches.
  assign pop_wr = (state == S_IDLE) && !wf_empty;
  assign pop_rd = (state == S_IDLE) && wf_empty && !rf_empty;
  assign pop_if = (state == S_IDLE) && wf_empty && rf_empty && !if_empty;

  assign idx       = req_addr[TAG_LSB-1:IDX_LSB];
  assign off       = req_addr[IDX_LSB-1:2];
  assign tag       = req_addr[ADDRBITS-1:TAG_LSB];
  assign d_tag_eq  = (d_tag[idx] == tag);
  assign hit       = (op == OP_IF) ? (i_valid[idx] && i_tag[idx] == tag) : (d_valid[idx] && d_tag_eq);
  // A fetch flushes only a same-tag dirty line; a data miss evicts a different-tag dirty line.
  assign need_wb   = d_valid[idx] && d_dirty[idx] && ((op == OP_IF) ? d_tag_eq : !d_tag_eq);
  assign fill_beat = (state == S_FILL) && waiting && !mem_rdreq && mem_out_valid;
  assign last_word = &cnt;

  function automatic logic [DATABITS-1:0] merge_word(input logic [DATABITS-1:0]    old_w,
                                                     input logic [DATABITS-1:0]    new_w,
                                                     input logic [WORDLENBITS-1:0] len,
                                                     input logic [1:0]             lane);
    logic [DATABITS-1:0] w;
    // NOTE: blocking assignments inside combinational code; w gets a full default first so nothing latches.
    w = old_w;
    if (len == WORDLENBITS'(0))      w[{lane, 3'b000} +: 8]     = new_w[7:0];
    else if (len == WORDLENBITS'(1)) w[{lane[1], 4'b0000} +: 16] = new_w[15:0];
    else                             w = new_w;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      op               <= OP_WR;
      req_addr         <= '0;
      req_data         <= '0;
      req_len          <= '0;
      cnt              <= '0;
      waiting          <= 1'b0;
      d_valid          <= '0;
      d_dirty          <= '0;
      i_valid          <= '0;
      dcache_out       <= '0;
      dcache_out_valid <= 1'b0;
      icache_out       <= '0;
      icache_out_valid <= 1'b0;
      mem_addr         <= '0;
      mem_in           <= '0;
      mem_wrreq        <= 1'b0;
      mem_rdreq        <= 1'b0;
    end else begin
      dcache_out_valid <= 1'b0;
      icache_out_valid <= 1'b0;
      mem_wrreq        <= 1'b0;
      mem_rdreq        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop_wr) begin
            op <= OP_WR; req_addr <= wf_addr; req_data <= wf_data; req_len <= wf_len;
            state <= S_LOOKUP;
          end else if (pop_rd) begin
            op <= OP_RD; req_addr <= rf_dout; state <= S_LOOKUP;
          end else if (pop_if) begin
            op <= OP_IF; req_addr <= if_dout; state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          cnt     <= '0;
          waiting <= 1'b0;
          if (hit)          state <= S_HIT_DONE;
          else if (need_wb) state <= S_WB;
          else              state <= S_FILL;
        end
        S_WB: begin
          mem_wrreq <= 1'b1;
          mem_addr  <= {d_tag[idx], idx, cnt, 2'b00};
          mem_in    <= d_data[idx][cnt];
          cnt       <= cnt + 1'b1;
          if (last_word) begin
            d_dirty[idx] <= 1'b0;
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (!waiting) begin
            mem_rdreq <= 1'b1;
            mem_addr  <= {tag, idx, cnt, 2'b00};
            waiting   <= 1'b1;
          end else if (fill_beat) begin
            waiting <= 1'b0;
            cnt     <= cnt + 1'b1;
            if (last_word) begin
              if (op == OP_IF) i_valid[idx] <= 1'b1;
              else begin
                d_valid[idx] <= 1'b1;
                d_dirty[idx] <= 1'b0;
              end
              state <= S_HIT_DONE;
            end
          end
        end
        S_HIT_DONE: begin
          state <= S_IDLE;
          case (op)
            OP_RD:   begin dcache_out <= d_data[idx][off]; dcache_out_valid <= 1'b1; end
            OP_IF:   begin icache_out <= i_data[idx][off]; icache_out_valid <= 1'b1; end
            default: d_dirty[idx] <= 1'b1;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tags and data need no reset: the valid bits above gate every use of them.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      if (op == OP_IF) i_data[idx][cnt] <= mem_out;
      else             d_data[idx][cnt] <= mem_out;
      if (last_word) begin
        if (op == OP_IF) i_tag[idx] <= tag;
        else             d_tag[idx] <= tag;
      end
    end
    if (state == S_HIT_DONE && op == OP_WR)
      d_data[idx][off] <= merge_word(d_data[idx][off], req_data, req_len, req_addr[1:0]);
  end
endmodule

// File: tb/tb_hybrid_cache.sv
// Directed bench for hybrid_cache with a registered 1024x32 word memory behind the port.

module tb_hybrid_cache;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dcache_rdaddr, dcache_wraddr, dcache_in, icache_rdaddr;
  logic        dcache_rdreq, dcache_wrreq, icache_rdreq;
  logic [1:0]  dcache_in_wordlen;
  logic [31:0] dcache_out, icache_out, mem_addr, mem_in, mem_out;
  logic        dcache_out_valid, dcache_rd_ready, dcache_wr_ready;
  logic        icache_out_valid, icache_rd_ready;
  logic        mem_out_valid, mem_wrreq, mem_rdreq;

  always #5 clk = ~clk;

  hybrid_cache dut (
    .clk(clk), .reset_n(reset_n),
    .dcache_rdaddr(dcache_rdaddr), .dcache_rdreq(dcache_rdreq),
    .dcache_out(dcache_out), .dcache_out_valid(dcache_out_valid), .dcache_rd_ready(dcache_rd_ready),
    .dcache_wraddr(dcache_wraddr), .dcache_wrreq(dcache_wrreq), .dcache_in(dcache_in),
    .dcache_in_wordlen(dcache_in_wordlen), .dcache_wr_ready(dcache_wr_ready),
    .icache_rdaddr(icache_rdaddr), .icache_rdreq(icache_rdreq),
    .icache_out(icache_out), .icache_out_valid(icache_out_valid), .icache_rd_ready(icache_rd_ready),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
    .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq)
  );

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    mem_out_valid <= 1'b0;
    if (mem_wrreq) mem[mem_addr[11:2]] <= mem_in;
    if (mem_rdreq) begin
      mem_out       <= mem[mem_addr[11:2]];
      mem_out_valid <= 1'b1;
    end
  end

  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, rd_cnt = 0, both_strobe = 0, both_valid = 0;
  logic [31:0] dq[$], iq[$];

  always @(negedge clk) begin
    if (mem_wrreq) wr_cnt++;
    if (mem_rdreq) rd_cnt++;
    if (mem_wrreq && mem_rdreq) both_strobe++;
    if (dcache_out_valid && icache_out_valid) both_valid++;
    if (dcache_out_valid) dq.push_back(dcache_out);
    if (icache_out_valid) iq.push_back(icache_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l, output bit acc);
    @(negedge clk);
    dcache_wrreq = 1'b1; dcache_wraddr = a; dcache_in = d; dcache_in_wordlen = l;
    acc = dcache_wr_ready;
  endtask

  task automatic rd_push(input logic [31:0] a);
    @(negedge clk);
    dcache_rdreq = 1'b1; dcache_rdaddr = a;
  endtask

  task automatic if_push(input logic [31:0] a);
    @(negedge clk);
    icache_rdreq = 1'b1; icache_rdaddr = a;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dcache_wrreq = 1'b0; dcache_rdreq = 1'b0; icache_rdreq = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic expect_d(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    int c = 0;
    while (dq.size() == 0 && c < 400) begin @(negedge clk); c++; end
    got = (dq.size() != 0) ? dq.pop_front() : 32'hDEAD_DEAD;
    check(tag, got, exp);
  endtask

  task automatic expect_i(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    int c = 0;
    while (iq.size() == 0 && c < 400) begin @(negedge clk); c++; end
    got = (iq.size() != 0) ? iq.pop_front() : 32'hDEAD_DEAD;
    check(tag, got, exp);
  endtask

  localparam bit EXP_ACC [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit acc;
    int w0, r0, c;
    logic [31:0] bp_addr [6];
    logic [31:0] bp_data [6];

    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    dcache_rdreq = 0; dcache_wrreq = 0; icache_rdreq = 0;
    dcache_rdaddr = 0; dcache_wraddr = 0; dcache_in = 0; dcache_in_wordlen = 0; icache_rdaddr = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wr_ready", dcache_wr_ready, 1);
    check("rst_rd_ready", dcache_rd_ready, 1);
    check("rst_if_ready", icache_rd_ready, 1);
    check("rst_mem_rdreq", mem_rdreq, 0);
    check("rst_mem_wrreq", mem_wrreq, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dvalid", dcache_out_valid, 0);
    check("rst_ivalid", icache_out_valid, 0);
    check("rst_dout", dcache_out, 0);

    // Four back-to-back stores into one line, then four reads.
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      store(32'h8000_0000 + 4 * i, 32'h0fff_0001 + i, 2'b10, acc);
      check($sformatf("st_acc%0d", i), 32'(acc), 1);
    end
    idle(60);
    check("st_fill_reads", rd_cnt - r0, 4);
    check("st_no_wb", wr_cnt - w0, 0);
    for (int i = 0; i < 4; i++) rd_push(32'h8000_0000 + 4 * i);
    idle(1);
    for (int i = 0; i < 4; i++) expect_d($sformatf("ld%0d", i), 32'h0fff_0001 + i);

    // Fetch the same words: dirty dcache line must reach memory first.
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 4; i++) if_push(32'h8000_0000 + 4 * i);
    idle(1);
    for (int i = 0; i < 4; i++) expect_i($sformatf("if%0d", i), 32'h0fff_0001 + i);
    check("if_wb_writes", wr_cnt - w0, 4);
    check("if_fill_reads", rd_cnt - r0, 4);
    check("if_mem0", mem[0], 32'h0fff_0001);
    check("if_mem3", mem[3], 32'h0fff_0004);

    // Eight stores to the same index, then read each back.
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      store(32'h100 + 32'h80 * i, 32'h100 + 32'h80 * i, 2'b10, acc);
      idle(50);
    end
    check("cf_st_wb", wr_cnt - w0, 28);
    for (int i = 0; i < 8; i++) begin
      rd_push(32'h100 + 32'h80 * i);
      idle(1);
      expect_d($sformatf("cf_ld%0d", i), 32'h100 + 32'h80 * i);
    end
    check("cf_total_wb", wr_cnt - w0, 32);
    check("cf_mem_100", mem[32'h100 >> 2], 32'h100);

    // Sub-word merges.
    store(32'h10, 32'h1122_3344, 2'b10, acc);
    store(32'h11, 32'h1234_56AA, 2'b00, acc);
    idle(50);
    rd_push(32'h10);
    idle(1);
    expect_d("byte_merge", 32'h1122_AA44);
    store(32'h12, 32'h0000_BEEF, 2'b01, acc);
    idle(50);
    rd_push(32'h13);
    idle(1);
    expect_d("half_merge", 32'hBEEF_AA44);

    // Backpressure: six stores back to back into a missing line.
    bp_addr = '{32'hE00, 32'hE04, 32'hE08, 32'hE0C, 32'hE00, 32'hE04};
    bp_data = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, 32'hB0B0_0000, 32'hB1B1_1111};
    for (int i = 0; i < 6; i++) begin
      store(bp_addr[i], bp_data[i], 2'b10, acc);
      check($sformatf("bp_acc%0d", i), 32'(acc), 32'(EXP_ACC[i]));
    end
    idle(80);
    check("bp_ready_back", dcache_wr_ready, 1);
    for (int i = 0; i < 4; i++) rd_push(32'hE00 + 4 * i);
    idle(1);
    expect_d("bp_w0", 32'hB0B0_0000);
    expect_d("bp_w1", 32'hA1A1_1111);
    expect_d("bp_w2", 32'hA2A2_2222);
    expect_d("bp_w3", 32'hA3A3_3333);

    // Reset in the middle of a fill.
    rd_push(32'h3040);
    idle(1);
    c = 0;
    while (!mem_rdreq && c < 100) begin @(negedge clk); c++; end
    check("rst_fill_seen", mem_rdreq, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rdreq", mem_rdreq, 0);
    check("mid_rst_wrreq", mem_wrreq, 0);
    check("mid_rst_rd_ready", dcache_rd_ready, 1);
    check("mid_rst_wr_ready", dcache_wr_ready, 1);
    reset_n = 1'b1;
    idle(5);
    check("mid_rst_no_out", dq.size(), 0);
    r0 = rd_cnt;
    rd_push(32'h3040);
    idle(1);
    expect_d("reread_val", 32'hA500_0010);
    check("reread_fill", rd_cnt - r0, 4);

    check("strobe_overlap", both_strobe, 0);
    check("valid_overlap", both_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
